// File: rtl/apb_pkg.sv
// Shared APB controller types: FSM state encoding and pprot bit positions.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  localparam int unsigned PROT_W      = 3;
  localparam int unsigned PROT_PRIV   = 0;
  localparam int unsigned PROT_NONSEC = 1;
  localparam int unsigned PROT_INSTR  = 2;

  // Build a pprot value from its named attribute bits.
  function automatic logic [PROT_W-1:0] make_prot(input logic priv, input logic nonsec,
                                                  input logic instr);
    logic [PROT_W-1:0] p;
    p              = '0;
    p[PROT_PRIV]   = priv;
    p[PROT_NONSEC] = nonsec;
    p[PROT_INSTR]  = instr;
    return p;
  endfunction

endpackage

// File: rtl/apb_master_ctrl_if.sv
// Command, response and APB4 bus signals of the APB master controller.
interface apb_master_ctrl_if
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [STRB_W-1:0] cmd_strb;
  logic [PROT_W-1:0] cmd_prot;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              rsp_timeout;

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [STRB_W-1:0] pstrb;
  logic [PROT_W-1:0] pprot;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
    input  prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    output psel, penable, pwrite, paddr, pwdata, pstrb, pprot
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
    output prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
    input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot
  );

endinterface

// File: rtl/apb_wait_timer.sv
// Counts consecutive ACCESS wait cycles; expired flags the cycle whose edge hits TIMEOUT.
module apb_wait_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  // Saturating so a disabled timeout never wraps back into a false match.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (TIMEOUT != 0) && enable && (count == LAST);

endmodule

// File: rtl/apb_master_ctrl.sv
// APB4 master: accepts one command at a time, runs SETUP/ACCESS, returns one response.
module apb_master_ctrl
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              resetn,
  apb_master_ctrl_if.master bus
);

  localparam int unsigned STRB_W = DATA_W / 8;

  apb_state_t        state;
  logic              psel_q;
  logic              penable_q;
  logic              pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic [STRB_W-1:0] pstrb_q;
  logic [PROT_W-1:0] pprot_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;
  logic              rsp_timeout_q;

  logic timer_clear;
  logic timer_enable;
  logic timer_expired;

  // The counter restarts on every SETUP so each ACCESS phase is timed from zero.
  assign timer_clear  = (state == SETUP);
  assign timer_enable = (state == ACCESS) && !bus.pready;

  apb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .resetn  (resetn),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .expired (timer_expired)
  );

  assign bus.cmd_ready = (state == IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      pprot_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            state    <= SETUP;
            psel_q   <= 1'b1;
            paddr_q  <= bus.cmd_addr;
            pwrite_q <= bus.cmd_write;
            pwdata_q <= bus.cmd_write ? bus.cmd_wdata : '0;
            pstrb_q  <= bus.cmd_write ? bus.cmd_strb : '0;
            pprot_q  <= bus.cmd_prot;
          end
        end
        SETUP: begin
          state     <= ACCESS;
          penable_q <= 1'b1;
        end
        ACCESS: begin
          // Completion wins over an expiry landing on the same edge.
          if (bus.pready) begin
            state       <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= bus.pslverr;
            rsp_rdata_q <= pwrite_q ? '0 : bus.prdata;
          end else if (timer_expired) begin
            state         <= IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
            rsp_rdata_q   <= '0;
          end
        end
        default: begin
          state     <= IDLE;
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.psel        = psel_q;
  assign bus.penable     = penable_q;
  assign bus.pwrite      = pwrite_q;
  assign bus.paddr       = paddr_q;
  assign bus.pwdata      = pwdata_q;
  assign bus.pstrb       = pstrb_q;
  assign bus.pprot       = pprot_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Bench for apb_master_ctrl: three instances (TIMEOUT 16, 4, 0) behind one stimulus/observe mux.
module tb_apb_master_ctrl;
  import apb_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  int          sel;
  logic        cmd_valid, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_strb;
  logic [2:0]  cmd_prot;
  logic        pready, pslverr;
  logic [DW-1:0] prdata;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic          cmd_ready;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [SW-1:0] pstrb;
    logic [2:0]    pprot;
  } dut_obs_t;

  dut_obs_t obs [3];
  dut_obs_t ob;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    apb_master_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    apb_master_ctrl #(
      .ADDR_W (AW),
      .DATA_W (DW),
      .TIMEOUT(g == 0 ? 16 : (g == 1 ? 4 : 0))
    ) u_dut (
      .clk   (clk),
      .resetn(resetn),
      .bus   (bus)
    );
    assign bus.cmd_valid = cmd_valid && (sel == g);
    assign bus.cmd_write = cmd_write;
    assign bus.cmd_addr  = cmd_addr;
    assign bus.cmd_wdata = cmd_wdata;
    assign bus.cmd_strb  = cmd_strb;
    assign bus.cmd_prot  = cmd_prot;
    assign bus.pready    = pready && (sel == g);
    assign bus.pslverr   = pslverr;
    assign bus.prdata    = prdata;
    assign obs[g] = {bus.cmd_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.rsp_timeout,
                     bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata, bus.pstrb, bus.pprot};
  end

  always_comb begin
    ob = obs[0];
    if (sel == 1) ob = obs[1];
    else if (sel == 2) ob = obs[2];
  end

  typedef struct {
    int          lat;
    int          acc;
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
    int          seq_bad;
    int          fld_bad;
    logic        rdy_issue;
    logic        rdy_rsp;
    logic        pulse2;
    logic [31:0] paddr_idle;
  } xfer_obs_t;

  function automatic int tmo_of(input int s);
    return (s == 0) ? 16 : ((s == 1) ? 4 : 0);
  endfunction

  // Reference response: a transfer aborts once tmo consecutive wait cycles pass.
  function automatic void ref_response(input int tmo, input logic wr, input int waits,
                                       input logic slverr, input logic [31:0] rd_in,
                                       output int lat, output int acc, output logic [31:0] rd,
                                       output logic err, output logic to);
    if (tmo > 0 && waits >= tmo) begin
      lat = 2 + tmo; acc = tmo; rd = 32'h0; err = 1'b1; to = 1'b1;
    end else begin
      lat = 3 + waits; acc = waits + 1; rd = wr ? 32'h0 : rd_in; err = slverr; to = 1'b0;
    end
  endfunction

  // Issues one command on the selected DUT and plays an APB slave with 'waits' wait states.
  task automatic run_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input logic [2:0] prot, input int waits,
                          input logic slverr, input logic [31:0] rdata, output xfer_obs_t o);
    logic [31:0] exp_wdata;
    logic [3:0]  exp_strb;
    bit          done;
    exp_wdata = wr ? wdata : 32'h0;
    exp_strb  = wr ? strb : 4'h0;
    o = '{default: 0};
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    cmd_strb = strb; cmd_prot = prot;
    #1 o.rdy_issue = ob.cmd_ready;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;
    cmd_strb = 4'($urandom); cmd_prot = 3'($urandom);
    done = 0;
    while (!done && o.lat < waits + 12) begin
      @(negedge clk);
      o.lat++;
      if (ob.rsp_valid) begin
        done = 1;
        o.rdata = ob.rsp_rdata; o.err = ob.rsp_err; o.tmo = ob.rsp_timeout;
        o.rdy_rsp = ob.cmd_ready; o.paddr_idle = ob.paddr;
        if (ob.psel || ob.penable) o.seq_bad++;
        pready = 1'b0; pslverr = 1'b0;
      end else begin
        if (ob.paddr !== addr || ob.pwrite !== wr || ob.pwdata !== exp_wdata ||
            ob.pstrb !== exp_strb || ob.pprot !== prot) o.fld_bad++;
        if (o.lat == 1) begin
          if (!(ob.psel === 1'b1 && ob.penable === 1'b0)) o.seq_bad++;
          pready = 1'b1; pslverr = 1'b1; prdata = $urandom;
        end else begin
          if (!(ob.psel === 1'b1 && ob.penable === 1'b1)) o.seq_bad++;
          o.acc++;
          pready  = (o.acc == waits + 1);
          pslverr = pready ? slverr : 1'($urandom);
          prdata  = pready ? rdata : $urandom;
        end
      end
    end
    pready = 1'b0; pslverr = 1'b0;
    @(negedge clk);
    o.pulse2 = ob.rsp_valid;
  endtask

  task automatic test_reset();
    xfer_obs_t o;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      n_tests++;
      if ({ob.psel, ob.penable, ob.pwrite, ob.rsp_valid, ob.rsp_err, ob.rsp_timeout} !== 6'b0) begin
        n_fail++; $display("FAIL reset_ctl[%0d]: got %b want 000000", s,
          {ob.psel, ob.penable, ob.pwrite, ob.rsp_valid, ob.rsp_err, ob.rsp_timeout});
      end
      n_tests++;
      if ((ob.paddr | ob.pwdata | ob.rsp_rdata | 32'(ob.pstrb) | 32'(ob.pprot)) !== 32'h0) begin
        n_fail++; $display("FAIL reset_data[%0d]: paddr=%h pwdata=%h rdata=%h want 0", s,
          ob.paddr, ob.pwdata, ob.rsp_rdata);
      end
      n_tests++;
      if (ob.cmd_ready !== 1'b1) begin
        n_fail++; $display("FAIL reset_ready[%0d]: got %b want 1", s, ob.cmd_ready);
      end
    end
    sel = 0;
    @(posedge clk); #2 resetn = 1'b1;
    run_xfer(1'b1, 32'h0000_0100, 32'hA5A5_0001, 4'hF, 3'b000, 0, 1'b0, 32'h0, o);
    n_tests++;
    if (o.rdy_issue !== 1'b1 || o.lat != 3) begin
      n_fail++; $display("FAIL first_after_reset: ready=%b lat=%0d want ready=1 lat=3", o.rdy_issue, o.lat);
    end
  endtask

  task automatic test_directed();
    xfer_obs_t o;
    logic wr, slv; logic [31:0] addr, wd, rd, e_rd; logic [3:0] st; int w, e_lat, e_acc;
    logic e_err, e_to; string nm;
    sel = 0;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: begin nm = "wr_zero_wait"; wr = 1; addr = 32'h10; wd = 32'hDEADBEEF; st = 4'hF; w = 0; slv = 0; rd = 0; end
        1: begin nm = "rd_3_waits";   wr = 0; addr = 32'h04; wd = 32'hCAFE0000; st = 4'hF; w = 3; slv = 0; rd = 32'h12345678; end
        default: begin nm = "wr_slverr"; wr = 1; addr = 32'h20; wd = $urandom; st = 4'h3; w = 1; slv = 1; rd = 0; end
      endcase
      run_xfer(wr, addr, wd, st, 3'b010, w, slv, rd, o);
      ref_response(16, wr, w, slv, rd, e_lat, e_acc, e_rd, e_err, e_to);
      n_tests++; if (o.lat != e_lat) begin n_fail++; $display("FAIL %s lat: got %0d want %0d", nm, o.lat, e_lat); end
      n_tests++; if (o.acc != e_acc) begin n_fail++; $display("FAIL %s access_cycles: got %0d want %0d", nm, o.acc, e_acc); end
      n_tests++; if (o.rdata !== e_rd) begin n_fail++; $display("FAIL %s rdata: got %h want %h", nm, o.rdata, e_rd); end
      n_tests++; if ({o.err, o.tmo} !== {e_err, e_to}) begin n_fail++; $display("FAIL %s err/tmo: got %b%b want %b%b", nm, o.err, o.tmo, e_err, e_to); end
      n_tests++; if (o.seq_bad != 0 || o.fld_bad != 0) begin n_fail++; $display("FAIL %s phases: seq_bad=%0d fld_bad=%0d want 0", nm, o.seq_bad, o.fld_bad); end
      n_tests++; if (o.rdy_rsp !== 1'b1 || o.pulse2 !== 1'b0) begin n_fail++; $display("FAIL %s rsp_cycle: ready=%b pulse2=%b want 1/0", nm, o.rdy_rsp, o.pulse2); end
      n_tests++; if (o.paddr_idle !== addr) begin n_fail++; $display("FAIL %s idle_hold: paddr=%h want %h", nm, o.paddr_idle, addr); end
    end
  endtask

  task automatic test_random();
    xfer_obs_t o;
    logic wr, slv; logic [31:0] addr, wd, rd, e_rd; logic [3:0] st; logic [2:0] pr;
    int w, e_lat, e_acc; logic e_err, e_to;
    sel = 0;
    for (int i = 0; i < 24; i++) begin
      wr = 1'($urandom); slv = 1'($urandom); addr = $urandom; wd = $urandom; rd = $urandom;
      st = 4'($urandom); pr = make_prot(1'($urandom), 1'($urandom), 1'($urandom));
      w = ($urandom_range(3, 0) == 0) ? int'($urandom_range(15, 6)) : int'($urandom_range(3, 0));
      run_xfer(wr, addr, wd, st, pr, w, slv, rd, o);
      ref_response(16, wr, w, slv, rd, e_lat, e_acc, e_rd, e_err, e_to);
      n_tests++;
      if (o.lat != e_lat || o.acc != e_acc || o.rdata !== e_rd || o.err !== e_err || o.tmo !== e_to) begin
        n_fail++; $display("FAIL rand[%0d] rsp: lat=%0d acc=%0d rd=%h err=%b to=%b want %0d %0d %h %b %b",
          i, o.lat, o.acc, o.rdata, o.err, o.tmo, e_lat, e_acc, e_rd, e_err, e_to);
      end
      n_tests++;
      if (o.seq_bad != 0 || o.fld_bad != 0 || o.pulse2 !== 1'b0) begin
        n_fail++; $display("FAIL rand[%0d] bus: seq_bad=%0d fld_bad=%0d pulse2=%b want 0 0 0",
          i, o.seq_bad, o.fld_bad, o.pulse2);
      end
    end
  endtask

  task automatic test_timeout();
    xfer_obs_t o;
    int s, w, e_lat, e_acc; logic [31:0] rd, e_rd; logic e_err, e_to;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: begin s = 1; w = 20; end
        1: begin s = 1; w = 3; end
        2: begin s = 1; w = 4; end
        default: begin s = 2; w = 100; end
      endcase
      sel = s; rd = $urandom;
      run_xfer(1'b0, 32'h0000_0200, 32'h0, 4'h0, 3'b001, w, 1'b0, rd, o);
      ref_response(tmo_of(s), 1'b0, w, 1'b0, rd, e_lat, e_acc, e_rd, e_err, e_to);
      n_tests++; if (o.lat != e_lat || o.acc != e_acc) begin n_fail++; $display("FAIL tmo[%0d] timing: lat=%0d acc=%0d want %0d %0d", i, o.lat, o.acc, e_lat, e_acc); end
      n_tests++; if ({o.err, o.tmo} !== {e_err, e_to}) begin n_fail++; $display("FAIL tmo[%0d] err/tmo: got %b%b want %b%b", i, o.err, o.tmo, e_err, e_to); end
      n_tests++; if (o.rdata !== e_rd) begin n_fail++; $display("FAIL tmo[%0d] rdata: got %h want %h", i, o.rdata, e_rd); end
      n_tests++; if (o.seq_bad != 0 || o.fld_bad != 0) begin n_fail++; $display("FAIL tmo[%0d] phases: seq_bad=%0d fld_bad=%0d want 0", i, o.seq_bad, o.fld_bad); end
    end
    sel = 0;
  endtask

  task automatic test_reset_mid();
    xfer_obs_t o;
    int bad;
    sel = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h40; cmd_prot = 3'b000;
    @(posedge clk); #1 cmd_valid = 1'b0; pready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_tests++;
    if ({ob.psel, ob.penable} !== 2'b11) begin n_fail++; $display("FAIL rst_mid_pre: psel/penable=%b want 11", {ob.psel, ob.penable}); end
    #2 resetn = 1'b0;
    #1;
    n_tests++;
    if ({ob.psel, ob.penable, ob.cmd_ready} !== 3'b001 || ob.paddr !== 32'h0) begin
      n_fail++; $display("FAIL rst_mid_async: psel/penable/ready=%b paddr=%h want 001 0",
        {ob.psel, ob.penable, ob.cmd_ready}, ob.paddr);
    end
    @(posedge clk);
    @(negedge clk); resetn = 1'b1;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (ob.rsp_valid || ob.psel) bad++;
    end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL rst_mid_no_rsp: %0d bad cycles want 0", bad); end
    run_xfer(1'b1, 32'h44, 32'h0BAD_F00D, 4'hC, 3'b000, 2, 1'b0, 32'h0, o);
    n_tests++;
    if (o.lat != 5 || o.err !== 1'b0 || o.tmo !== 1'b0 || o.seq_bad != 0 || o.fld_bad != 0) begin
      n_fail++; $display("FAIL rst_mid_after: lat=%0d err=%b to=%b seq=%0d fld=%0d want 5 0 0 0 0",
        o.lat, o.err, o.tmo, o.seq_bad, o.fld_bad);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [4];
    logic        wrs [4];
    logic [31:0] addr_q [$];
    logic        wr_q [$];
    logic [31:0] rd_q [$];
    logic [31:0] e_rd;
    int acc_cyc [4];
    int nacc, nrsp, ready_bad, addr_bad, rsp_bad;
    bit accepted;
    sel = 0;
    for (int i = 0; i < 4; i++) begin addrs[i] = $urandom & 32'hFFFF_FFFC; wrs[i] = 1'($urandom); end
    nacc = 0; nrsp = 0; ready_bad = 0; addr_bad = 0; rsp_bad = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wrs[0]; cmd_addr = addrs[0]; cmd_wdata = $urandom;
    cmd_strb = 4'hF; cmd_prot = 3'b000;
    for (int t = 0; t < 30 && nrsp < 4; t++) begin
      if (ob.rsp_valid) begin
        if (rd_q.size() == 0) rsp_bad++;
        else begin
          e_rd = rd_q.pop_front();
          if (ob.rsp_rdata !== e_rd || ob.rsp_err !== 1'b0) rsp_bad++;
        end
        nrsp++;
      end
      if (ob.psel && ob.cmd_ready) ready_bad++;
      pslverr = 1'b0; prdata = $urandom;
      pready = ob.psel && ob.penable;
      if (ob.psel && ob.penable) begin
        if (addr_q.size() == 0 || wr_q.size() == 0) addr_bad++;
        else begin
          if (ob.paddr !== addr_q.pop_front()) addr_bad++;
          rd_q.push_back(wr_q.pop_front() ? 32'h0 : prdata);
        end
      end
      accepted = cmd_valid && ob.cmd_ready;
      if (accepted) begin
        acc_cyc[nacc] = t; addr_q.push_back(addrs[nacc]); wr_q.push_back(wrs[nacc]); nacc++;
      end
      @(posedge clk); #1;
      if (accepted) begin
        if (nacc < 4) begin cmd_write = wrs[nacc]; cmd_addr = addrs[nacc]; cmd_wdata = $urandom; end
        else cmd_valid = 1'b0;
      end
      @(negedge clk);
    end
    pready = 1'b0; cmd_valid = 1'b0;
    n_tests++;
    if (nacc != 4 || nrsp != 4) begin n_fail++; $display("FAIL b2b_count: accepts=%0d rsps=%0d want 4 4", nacc, nrsp); end
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (i + 1 < nacc && acc_cyc[i + 1] - acc_cyc[i] != 3) begin
        n_fail++; $display("FAIL b2b_spacing[%0d]: got %0d want 3", i, acc_cyc[i + 1] - acc_cyc[i]);
      end else if (i + 1 >= nacc) begin
        n_fail++; $display("FAIL b2b_spacing[%0d]: accept missing", i);
      end
    end
    n_tests++;
    if (ready_bad != 0 || addr_bad != 0 || rsp_bad != 0) begin
      n_fail++; $display("FAIL b2b_order: ready_bad=%0d addr_bad=%0d rsp_bad=%0d want 0", ready_bad, addr_bad, rsp_bad);
    end
  endtask

  initial begin
    sel = 0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_strb = '0; cmd_prot = '0; pready = 1'b0; pslverr = 1'b0; prdata = '0;
    test_reset();
    test_directed();
    test_random();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
